// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the architectural PC, addresses the instruction ROM
// and loads the IF/ID pipeline register. An address error freezes fetch until reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IMEM_AW  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect,
  input  logic [31:0]        redirect_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc,
  output logic [31:0]        instr_d,
  output logic [31:0]        pc_d,
  output logic               valid_d,
  output logic [31:0]        fetch_count,
  output logic               halted,
  output logic [1:0]         err_cause
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [1:0]  ERR_NONE     = 2'b00;
  localparam logic [1:0]  ERR_MISALIGN = 2'b01;
  localparam logic [1:0]  ERR_RANGE    = 2'b10;
  // One past the last ROM byte; 33 bits so a ROM ending at 4 GiB cannot wrap.
  localparam logic [32:0] PC_LIMIT     = {1'b0, RESET_PC} + (33'd4 << IMEM_AW);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d_nxt;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] count_q, count_d;
  logic [1:0]  err_q, err_d;

  logic [31:0] seq_pc;
  logic [31:0] next_pc;
  logic        misaligned;
  logic        out_of_range;

  assign seq_pc       = pc_q + 32'd4;
  assign next_pc      = redirect ? redirect_target : seq_pc;
  assign misaligned   = redirect && (redirect_target[1:0] != 2'b00);
  assign out_of_range = ({1'b0, next_pc} < {1'b0, RESET_PC}) ||
                        ({1'b0, next_pc} >= PC_LIMIT);

  assign imem_addr = IMEM_AW'((pc_q - RESET_PC) >> 2);

  always_comb begin
    state_d      = state_q;
    pc_d_nxt     = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    count_d      = count_q;
    err_d        = err_q;
    case (state_q)
      ST_RUN: begin
        // A stalled redirect/flush is dropped; decode re-asserts it later.
        if (!stall) begin
          pc_d_nxt  = next_pc;
          ifid_pc_d = pc_q;
          if (flush) begin
            ifid_instr_d = 32'd0;
            ifid_valid_d = 1'b0;
          end else begin
            ifid_instr_d = imem_rdata;
            ifid_valid_d = 1'b1;
            count_d      = count_q + 32'd1;
          end
          if (misaligned) begin
            state_d = ST_HALT;
            err_d   = ERR_MISALIGN;
          end else if (out_of_range) begin
            state_d = ST_HALT;
            err_d   = ERR_RANGE;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      ifid_instr_q <= 32'd0;
      ifid_pc_q    <= 32'd0;
      ifid_valid_q <= 1'b0;
      count_q      <= 32'd0;
      err_q        <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d_nxt;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  assign pc          = pc_q;
  assign instr_d     = ifid_instr_q;
  assign pc_d        = ifid_pc_q;
  assign valid_d     = ifid_valid_q;
  assign fetch_count = count_q;
  assign halted      = (state_q == ST_HALT);
  assign err_cause   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 4096-word instance for normal flow and errors,
// and a 16-word instance for sequential overflow. ROM[i] = i + 1 in both.
module tb_fetch_unit;

  logic clk;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Instance A: IMEM_AW = 12
  logic        rst_a, stall_a, flush_a, redirect_a;
  logic [31:0] target_a;
  logic [11:0] addr_a;
  logic [31:0] rdata_a, pc_a, instr_a, pcd_a, count_a;
  logic        valid_a, halted_a;
  logic [1:0]  err_a;

  // Instance B: IMEM_AW = 4
  logic        rst_b, stall_b, flush_b, redirect_b;
  logic [31:0] target_b;
  logic [3:0]  addr_b;
  logic [31:0] rdata_b, pc_b, instr_b, pcd_b, count_b;
  logic        valid_b, halted_b;
  logic [1:0]  err_b;

  assign rdata_a = {20'd0, addr_a} + 32'd1;
  assign rdata_b = {28'd0, addr_b} + 32'd1;

  fetch_unit #(.RESET_PC(32'h0000_3000), .IMEM_AW(12)) dut_a (
    .clk(clk), .rst(rst_a), .stall(stall_a), .flush(flush_a),
    .redirect(redirect_a), .redirect_target(target_a),
    .imem_addr(addr_a), .imem_rdata(rdata_a), .pc(pc_a),
    .instr_d(instr_a), .pc_d(pcd_a), .valid_d(valid_a),
    .fetch_count(count_a), .halted(halted_a), .err_cause(err_a)
  );

  fetch_unit #(.RESET_PC(32'h0000_3000), .IMEM_AW(4)) dut_b (
    .clk(clk), .rst(rst_b), .stall(stall_b), .flush(flush_b),
    .redirect(redirect_b), .redirect_target(target_b),
    .imem_addr(addr_b), .imem_rdata(rdata_b), .pc(pc_b),
    .instr_d(instr_b), .pc_d(pcd_b), .valid_d(valid_b),
    .fetch_count(count_b), .halted(halted_b), .err_cause(err_b)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver: advance one edge, land 1 ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                       input logic [31:0] e_pcd, input logic e_valid, input logic [31:0] e_cnt);
    check_eq({tag, ".pc"},      pc_a,    e_pc);
    check_eq({tag, ".instr_d"}, instr_a, e_instr);
    check_eq({tag, ".pc_d"},    pcd_a,   e_pcd);
    check_eq({tag, ".valid_d"}, {31'd0, valid_a}, {31'd0, e_valid});
    check_eq({tag, ".count"},   count_a, e_cnt);
  endtask

  task automatic chk_err_a(input string tag, input logic e_halt, input logic [1:0] e_err);
    check_eq({tag, ".halted"}, {31'd0, halted_a}, {31'd0, e_halt});
    check_eq({tag, ".err"},    {30'd0, err_a},    {30'd0, e_err});
  endtask

  initial begin
    rst_a = 1'b1; stall_a = 1'b0; flush_a = 1'b0; redirect_a = 1'b0; target_a = 32'd0;
    rst_b = 1'b1; stall_b = 1'b0; flush_b = 1'b0; redirect_b = 1'b0; target_b = 32'd0;
    #12;
    chk_a("reset", 32'h3000, 32'd0, 32'd0, 1'b0, 32'd0);
    chk_err_a("reset", 1'b0, 2'b00);
    check_eq("reset.imem_addr", {20'd0, addr_a}, 32'd0);
    rst_a = 1'b0;

    // free-running, ROM word at PC P appears one edge later
    for (int k = 1; k <= 2; k++) begin
      step();
      chk_a($sformatf("run%0d", k), 32'h3000 + 4 * k, k, 32'h3000 + 4 * (k - 1), 1'b1, k);
    end

    // stall two cycles at pc=3008
    stall_a = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk_a($sformatf("stall%0d", k), 32'h3008, 32'd2, 32'h3004, 1'b1, 32'd2);
    end
    stall_a = 1'b0;
    for (int k = 3; k <= 4; k++) begin
      step();
      chk_a($sformatf("run%0d", k), 32'h3000 + 4 * k, k, 32'h3000 + 4 * (k - 1), 1'b1, k);
    end

    // redirect to 3100 with delay slot at 3010
    redirect_a = 1'b1; target_a = 32'h3100;
    step();
    chk_a("redir", 32'h3100, 32'd5, 32'h3010, 1'b1, 32'd5);
    redirect_a = 1'b0;
    check_eq("redir.imem_addr", {20'd0, addr_a}, 32'h40);
    step();
    chk_a("redir_tgt", 32'h3104, 32'h41, 32'h3100, 1'b1, 32'd6);

    // stall drops a concurrent redirect
    stall_a = 1'b1; redirect_a = 1'b1; target_a = 32'h3200;
    step();
    chk_a("stall_redir", 32'h3104, 32'h41, 32'h3100, 1'b1, 32'd6);
    stall_a = 1'b0;

    // flush + redirect on the same edge
    flush_a = 1'b1;
    step();
    chk_a("flush_redir", 32'h3200, 32'd0, 32'h3104, 1'b0, 32'd6);
    redirect_a = 1'b0;
    step();
    chk_a("flush", 32'h3204, 32'd0, 32'h3200, 1'b0, 32'd6);
    flush_a = 1'b0;
    step();
    chk_a("after_flush", 32'h3208, 32'h82, 32'h3204, 1'b1, 32'd7);

    // misaligned redirect halts; delay slot still loads
    redirect_a = 1'b1; target_a = 32'h3102;
    step();
    chk_a("misal", 32'h3102, 32'h83, 32'h3208, 1'b1, 32'd8);
    chk_err_a("misal", 1'b1, 2'b01);
    stall_a = 1'b1; flush_a = 1'b1; target_a = 32'h3300;
    step();
    chk_a("halt_stall", 32'h3102, 32'h83, 32'h3208, 1'b1, 32'd8);
    stall_a = 1'b0;
    step();
    chk_a("halt_flush", 32'h3102, 32'h83, 32'h3208, 1'b1, 32'd8);
    chk_err_a("halt_flush", 1'b1, 2'b01);

    // asynchronous reset mid-cycle
    #2; rst_a = 1'b1; #1;
    chk_a("async_rst", 32'h3000, 32'd0, 32'd0, 1'b0, 32'd0);
    chk_err_a("async_rst", 1'b0, 2'b00);
    flush_a = 1'b0; target_a = 32'h0000_0002;
    rst_a = 1'b0;

    // misaligned and out of range together: misaligned wins
    step();
    check_eq("both.pc", pc_a, 32'h0000_0002);
    chk_err_a("both", 1'b1, 2'b01);

    // below the ROM base
    #1; rst_a = 1'b1; #1; rst_a = 1'b0;
    target_a = 32'h0000_2FFC;
    step();
    check_eq("low.pc", pc_a, 32'h0000_2FFC);
    check_eq("low.instr_d", instr_a, 32'd1);
    chk_err_a("low", 1'b1, 2'b10);

    // last word of the 4096-word ROM, then overflow
    #1; rst_a = 1'b1; #1; rst_a = 1'b0;
    target_a = 32'h0000_6FFC;
    step();
    check_eq("top.pc", pc_a, 32'h0000_6FFC);
    chk_err_a("top", 1'b0, 2'b00);
    redirect_a = 1'b0;
    check_eq("top.imem_addr", {20'd0, addr_a}, 32'hFFF);
    step();
    chk_a("top_ovf", 32'h7000, 32'h1000, 32'h6FFC, 1'b1, 32'd2);
    chk_err_a("top_ovf", 1'b1, 2'b10);

    // instance B: sequential run off the end of a 16-word ROM
    rst_b = 1'b0;
    repeat (15) step();
    check_eq("b_last.pc", pc_b, 32'h303C);
    check_eq("b_last.instr_d", instr_b, 32'd15);
    check_eq("b_last.imem_addr", {28'd0, addr_b}, 32'd15);
    check_eq("b_last.halted", {31'd0, halted_b}, 32'd0);
    step();
    check_eq("b_ovf.pc", pc_b, 32'h3040);
    check_eq("b_ovf.instr_d", instr_b, 32'd16);
    check_eq("b_ovf.pc_d", pcd_b, 32'h303C);
    check_eq("b_ovf.valid_d", {31'd0, valid_b}, 32'd1);
    check_eq("b_ovf.count", count_b, 32'd16);
    check_eq("b_ovf.halted", {31'd0, halted_b}, 32'd1);
    check_eq("b_ovf.err", {30'd0, err_b}, 32'd2);
    step();
    check_eq("b_hold.pc", pc_b, 32'h3040);
    check_eq("b_hold.count", count_b, 32'd16);
    #2; rst_b = 1'b1; #1;
    check_eq("b_rst.pc", pc_b, 32'h3000);
    check_eq("b_rst.halted", {31'd0, halted_b}, 32'd0);
    check_eq("b_rst.err", {30'd0, err_b}, 32'd0);
    check_eq("b_rst.count", count_b, 32'd0);
    rst_b = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
